// File: rtl/jk_universal_reg.sv
// WIDTH-bit register with per-bit JK, parallel load, up/down count and
// bidirectional shift modes; synchronous clear has highest priority.
module jk_universal_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             ser_out,
    output logic             tc,
    output logic             ovf
);

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_COUNT = 2'b10,
        MODE_SHIFT = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    mode_e            op;
    logic [WIDTH-1:0] q_next;
    logic             ovf_next;

    assign op      = mode_e'(mode);
    assign qbar    = ~q;
    assign ser_out = dir ? q[WIDTH-1] : q[0];
    assign tc      = dir ? (&q) : ~(|q);

    always_comb begin
        q_next   = q;
        ovf_next = 1'b0;
        unique case (op)
            // Per-bit JK characteristic equation: q+ = j&~q | ~k&q
            MODE_JK:    q_next = (j & ~q) | (~k & q);
            MODE_LOAD:  q_next = d;
            MODE_COUNT: begin
                if (tc) begin
                    ovf_next = 1'b1;
                    if (!SATURATE) q_next = dir ? '0 : '1;
                end else begin
                    q_next = dir ? (q + ONE) : (q - ONE);
                end
            end
            MODE_SHIFT: q_next = dir ? {q[WIDTH-2:0], ser_in} : {ser_in, q[WIDTH-1:1]};
            default:    q_next = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q   <= RESET_VAL;
            ovf <= 1'b0;
        end else if (enable) begin
            q   <= q_next;
            ovf <= ovf_next;
        end else begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jk_universal_reg.sv
// Bench for jk_universal_reg: three WIDTH=4 instances (wrap, saturate, RESET_VAL=0101)
// share stimulus and are compared against an integer reference model.
module tb_jk_universal_reg;

    logic       clk = 1'b0;
    logic       clr, enable, dir, ser_in;
    logic [1:0] mode;
    logic [3:0] j, k, d;

    logic [3:0] q_o    [3];
    logic [3:0] qbar_o [3];
    logic       so_o   [3];
    logic       tc_o   [3];
    logic       ovf_o  [3];

    int checks = 0;
    int errors = 0;
    int mq   [3];
    int movf [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        jk_universal_reg #(
            .WIDTH     (4),
            .SATURATE  (g == 1),
            .RESET_VAL ((g == 2) ? 4'b0101 : 4'b0000)
        ) dut (
            .clk     (clk),
            .clr     (clr),
            .enable  (enable),
            .mode    (mode),
            .dir     (dir),
            .j       (j),
            .k       (k),
            .d       (d),
            .ser_in  (ser_in),
            .q       (q_o[g]),
            .qbar    (qbar_o[g]),
            .ser_out (so_o[g]),
            .tc      (tc_o[g]),
            .ovf     (ovf_o[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: register value as an integer 0..15
    task automatic model_step(input int g);
        int sat = (g == 1);
        int rv  = (g == 2) ? 5 : 0;
        int nv;
        if (clr) begin
            mq[g] = rv; movf[g] = 0;
        end else if (!enable) begin
            movf[g] = 0;
        end else begin
            movf[g] = 0;
            case (mode)
                2'd0: for (int i = 0; i < 4; i++) begin
                    if (j[i] && k[i])  mq[g] = mq[g] ^ (1 << i);
                    else if (j[i])     mq[g] = mq[g] | (1 << i);
                    else if (k[i])     mq[g] = mq[g] & ~(1 << i);
                end
                2'd1: mq[g] = int'(d);
                2'd2: begin
                    nv = mq[g] + (dir ? 1 : -1);
                    if (nv < 0 || nv > 15) begin
                        movf[g] = 1;
                        if (!sat) mq[g] = (nv + 16) % 16;
                    end else begin
                        mq[g] = nv;
                    end
                end
                default: begin
                    if (dir) mq[g] = ((mq[g] << 1) | int'(ser_in)) & 15;
                    else     mq[g] = (mq[g] >> 1) | (int'(ser_in) << 3);
                end
            endcase
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("q%0d", g),    q_o[g],    mq[g]);
            chk($sformatf("qbar%0d", g), qbar_o[g], (~mq[g]) & 15);
            chk($sformatf("ovf%0d", g),  ovf_o[g],  movf[g]);
            chk($sformatf("ser%0d", g),  so_o[g],   dir ? ((mq[g] >> 3) & 1) : (mq[g] & 1));
            chk($sformatf("tc%0d", g),   tc_o[g],   dir ? (mq[g] == 15) : (mq[g] == 0));
        end
    endtask

    task automatic drive(input logic c, input logic e, input logic [1:0] m, input logic dr,
                         input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] dd,
                         input logic s);
        clr = c; enable = e; mode = m; dir = dr; j = jj; k = kk; d = dd; ser_in = s;
        @(posedge clk);
        for (int g = 0; g < 3; g++) model_step(g);
        #1;
        check_all();
    endtask

    initial begin
        // Reset with load requested, then release
        drive(1, 1, 2'b01, 0, 4'h0, 4'h0, 4'b1010, 0);
        drive(1, 1, 2'b01, 0, 4'h0, 4'h0, 4'b1010, 0);
        chk("rst_q", q_o[0], 4'b0000);
        chk("rst_qbar", qbar_o[0], 4'b1111);
        chk("rst_ovf", ovf_o[0], 1'b0);
        chk("rst_q_rv", q_o[2], 4'b0101);
        drive(0, 1, 2'b01, 0, 4'h0, 4'h0, 4'b1010, 0);
        chk("load", q_o[0], 4'b1010);

        // JK mixed codes, then enable low
        drive(0, 1, 2'b01, 0, 4'h0, 4'h0, 4'b1100, 0);
        drive(0, 1, 2'b00, 0, 4'b1010, 4'b0110, 4'h0, 0);
        chk("jk_mix", q_o[0], 4'b1010);
        drive(0, 0, 2'b00, 0, 4'hf, 4'hf, 4'h0, 0);
        chk("jk_hold", q_o[0], 4'b1010);

        // Count up across the top, then down across zero
        drive(0, 1, 2'b01, 1, 4'h0, 4'h0, 4'b1110, 0);
        drive(0, 1, 2'b10, 1, 4'h0, 4'h0, 4'h0, 0);
        chk("up_1111", q_o[0], 4'b1111);
        chk("up_tc", tc_o[0], 1'b1);
        drive(0, 1, 2'b10, 1, 4'h0, 4'h0, 4'h0, 0);
        chk("wrap_q", q_o[0], 4'b0000);
        chk("wrap_ovf", ovf_o[0], 1'b1);
        chk("sat_q", q_o[1], 4'b1111);
        chk("sat_ovf", ovf_o[1], 1'b1);
        drive(0, 1, 2'b10, 1, 4'h0, 4'h0, 4'h0, 0);
        chk("after_wrap", q_o[0], 4'b0001);
        chk("after_wrap_ovf", ovf_o[0], 1'b0);
        chk("sat_again", ovf_o[1], 1'b1);
        drive(0, 1, 2'b01, 0, 4'h0, 4'h0, 4'b0000, 0);
        drive(0, 1, 2'b10, 0, 4'h0, 4'h0, 4'h0, 0);
        chk("down_wrap", q_o[0], 4'b1111);
        chk("down_ovf", ovf_o[0], 1'b1);
        chk("down_sat", q_o[1], 4'b0000);

        // Shift both directions
        drive(0, 1, 2'b01, 1, 4'h0, 4'h0, 4'b1001, 1);
        chk("so_left", so_o[0], 1'b1);
        drive(0, 1, 2'b11, 1, 4'h0, 4'h0, 4'h0, 1);
        chk("shl", q_o[0], 4'b0011);
        drive(0, 1, 2'b11, 0, 4'h0, 4'h0, 4'h0, 0);
        chk("shr", q_o[0], 4'b0001);

        // Clear mid-count with non-zero RESET_VAL
        drive(0, 1, 2'b01, 1, 4'h0, 4'h0, 4'b0111, 0);
        drive(0, 1, 2'b10, 1, 4'h0, 4'h0, 4'h0, 0);
        drive(1, 1, 2'b10, 1, 4'h0, 4'h0, 4'h0, 0);
        chk("clr_mid", q_o[2], 4'b0101);
        chk("clr_ovf", ovf_o[2], 1'b0);
        drive(0, 1, 2'b10, 1, 4'h0, 4'h0, 4'h0, 0);
        chk("resume", q_o[2], 4'b0110);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) != 0),
                  2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom), 4'($urandom),
                  4'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
